// File: rtl/inst_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// inst_fetch_ctrl
//   Fetch-side bus controller. Issues the IF-stage PC on an SRAM-like
//   instruction bus (req / addr_ok / data_ok), keeps at most one transaction
//   outstanding, and hands the fetched word plus its PC to ID through a
//   valid / allowin handshake. IF_stall holds the PC register until the
//   instruction is handed off or a redirect (flush) arrives.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   IF_in_PC          current fetch PC from the IF stage
//   flush             redirect; the PC register loads a new value next edge
//   out_allowin       ID can accept an instruction this cycle
//   IF_stall          hold the PC register
//   IF_out_valid      IF_out_PC / IF_out_inst valid to ID
//   IF_out_PC         PC of the delivered instruction
//   IF_out_inst       delivered instruction word
//   inst_req/wr/size/addr/wdata, inst_addr_ok/rdata/data_ok   instruction bus
//   IF_out_adef       address-error flag (only with INST_FETCH_ADEF_EN)
//
// Build option
//   INST_FETCH_ADEF_EN  when defined, a misaligned PC is not put on the bus;
//                       it is delivered straight to ID with IF_out_adef set.
//
// state  | meaning
// IDLE   | just out of reset, nothing issued
// REQ    | request on the bus, waiting for addr_ok
// WAIT   | address accepted, waiting for data_ok
// DONE   | instruction held for ID, waiting for handoff
// CANCEL | flushed while a request was in flight; drain its data_ok
// -----------------------------------------------------------------------------
module inst_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] IF_in_PC,
    input  logic        flush,
    input  logic        out_allowin,
    output logic        IF_stall,
    output logic        IF_out_valid,
    output logic [31:0] IF_out_PC,
    output logic [31:0] IF_out_inst,
    output logic        inst_req,
    output logic        inst_wr,
    output logic [1:0]  inst_size,
    output logic [31:0] inst_addr,
    output logic [31:0] inst_wdata,
    input  logic        inst_addr_ok,
    input  logic [31:0] inst_rdata,
    input  logic        inst_data_ok
`ifdef INST_FETCH_ADEF_EN
    ,
    output logic        IF_out_adef
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE,
        S_CANCEL
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
`ifdef INST_FETCH_ADEF_EN
    logic        adef_q, adef_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            pc_q   <= RESET_PC;
            inst_q <= '0;
`ifdef INST_FETCH_ADEF_EN
            adef_q <= 1'b0;
`endif
        end else begin
            state  <= state_nxt;
            pc_q   <= pc_d;
            inst_q <= inst_d;
`ifdef INST_FETCH_ADEF_EN
            adef_q <= adef_d;
`endif
        end
    end

    always_comb begin
        state_nxt    = state;
        pc_d         = pc_q;
        inst_d       = inst_q;
        inst_req     = 1'b0;
        IF_out_valid = 1'b0;
`ifdef INST_FETCH_ADEF_EN
        adef_d       = adef_q;
`endif
        case (state)
            S_IDLE: state_nxt = S_REQ;
            S_REQ: begin
`ifdef INST_FETCH_ADEF_EN
                // A misaligned fetch never reaches the bus. A simultaneous
                // flush wins: the redirected PC is re-examined next cycle.
                if (IF_in_PC[1:0] != 2'b00) begin
                    if (!flush) begin
                        pc_d      = IF_in_PC;
                        inst_d    = '0;
                        adef_d    = 1'b1;
                        state_nxt = S_DONE;
                    end
                end else
`endif
                begin
                    inst_req = 1'b1;
                    if (inst_addr_ok) begin
                        if (flush) begin
                            state_nxt = S_CANCEL;
                        end else begin
                            pc_d      = IF_in_PC;
                            state_nxt = S_WAIT;
                        end
                    end
                end
            end
            S_WAIT: begin
                if (flush) begin
                    state_nxt = inst_data_ok ? S_REQ : S_CANCEL;
                end else if (inst_data_ok) begin
                    inst_d    = inst_rdata;
                    state_nxt = S_DONE;
                end
            end
            S_CANCEL: begin
                if (inst_data_ok) state_nxt = S_REQ;
            end
            S_DONE: begin
                // flush masks delivery combinationally and takes priority
                IF_out_valid = !flush;
                if (flush || out_allowin) begin
                    state_nxt = S_REQ;
`ifdef INST_FETCH_ADEF_EN
                    adef_d    = 1'b0;
`endif
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign IF_stall    = !(((state == S_DONE) && out_allowin) || flush);
    assign IF_out_PC   = pc_q;
    assign IF_out_inst = inst_q;
    assign inst_wr     = 1'b0;
    assign inst_size   = 2'd2;
    assign inst_addr   = IF_in_PC;
    assign inst_wdata  = '0;
`ifdef INST_FETCH_ADEF_EN
    assign IF_out_adef = adef_q;
`endif

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch_ctrl
//   Bench for inst_fetch_ctrl. The bench owns the PC register and a bus slave
//   with programmable addr_ok / data_ok delays. A transaction-level model
//   (one instruction awaiting handoff, one bus transaction in flight, killed
//   by flush) predicts req / valid / stall / delivered PC+inst every cycle.
// -----------------------------------------------------------------------------
module tb_inst_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_in_pc;
    logic        flush;
    logic        out_allowin;
    logic        if_stall;
    logic        if_out_valid;
    logic [31:0] if_out_pc;
    logic [31:0] if_out_inst;
    logic        inst_req;
    logic        inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr;
    logic [31:0] inst_wdata;
    logic        inst_addr_ok;
    logic [31:0] inst_rdata;
    logic        inst_data_ok;
`ifdef INST_FETCH_ADEF_EN
    logic        if_out_adef;
`endif

    always #5 clk = ~clk;

    inst_fetch_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .IF_in_PC     (if_in_pc),
        .flush        (flush),
        .out_allowin  (out_allowin),
        .IF_stall     (if_stall),
        .IF_out_valid (if_out_valid),
        .IF_out_PC    (if_out_pc),
        .IF_out_inst  (if_out_inst),
        .inst_req     (inst_req),
        .inst_wr      (inst_wr),
        .inst_size    (inst_size),
        .inst_addr    (inst_addr),
        .inst_wdata   (inst_wdata),
        .inst_addr_ok (inst_addr_ok),
        .inst_rdata   (inst_rdata),
        .inst_data_ok (inst_data_ok)
`ifdef INST_FETCH_ADEF_EN
        ,
        .IF_out_adef  (if_out_adef)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    // model
    bit          m_started, m_have, m_txn, m_live, m_adef;
    logic [31:0] m_pc, m_inst, m_txn_pc;
    logic [31:0] pc_reg;

    // slave
    bit          s_busy;
    int          s_req_cnt, s_data_cnt;
    logic [31:0] s_data;
    int          addr_delay = 0;
    int          data_delay = 0;
    bit          force_en   = 0;
    logic [31:0] force_data = 32'h0;

    // observations for literal checks
    int          cyc = 0;
    int          first_valid_cyc = -1;
    int          req_cycles, accepts, valid_cycles, stall_low_cnt;
    logic [31:0] last_req_addr, last_valid_pc, last_valid_inst;
    logic        obs_valid, obs_stall;
    bit          saw_deadbeef;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem(input logic [31:0] a);
        if (a == 32'hbfc00000) return 32'h3c1d0001;
        return a ^ 32'h13570000;
    endfunction

    task automatic model_reset();
        m_started = 0; m_have = 0; m_txn = 0; m_live = 0; m_adef = 0;
        m_pc = 32'h0; m_inst = 32'h0; m_txn_pc = 32'h0;
        pc_reg = 32'hbfc00000;
        s_busy = 0; s_req_cnt = 0; s_data_cnt = 0; s_data = 32'h0;
    endtask

    task automatic reset_checks();
        chk("rst_valid", if_out_valid, 0);
        chk("rst_req",   inst_req, 0);
        chk("rst_pc",    if_out_pc, 32'hbfc00000);
        chk("rst_inst",  if_out_inst, 0);
        chk("rst_stall", if_stall, 1);
`ifdef INST_FETCH_ADEF_EN
        chk("rst_adef",  if_out_adef, 0);
`endif
    endtask

    // One clock cycle: drive inputs, let the slave answer, compare, clock, update.
    task automatic step(input bit f, input logic [31:0] tgt, input bit allow);
        bit exp_req, exp_valid, exp_stall, aligned, free;
        @(negedge clk);
        if_in_pc     = pc_reg;
        flush        = f;
        out_allowin  = allow;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        inst_rdata   = $urandom;
        #1;
        inst_addr_ok = inst_req && (s_req_cnt >= addr_delay);
        inst_data_ok = s_busy && (s_data_cnt >= data_delay);
        if (inst_data_ok) inst_rdata = s_data;
        #1;
        aligned = 1;
`ifdef INST_FETCH_ADEF_EN
        aligned = (pc_reg[1:0] == 2'b00);
`endif
        free      = m_started && !m_have && !m_txn;
        exp_req   = free && aligned;
        exp_valid = m_have && !f;
        exp_stall = !((m_have && allow) || f);
        chk("inst_req", inst_req, exp_req);
        chk("IF_out_valid", if_out_valid, exp_valid);
        chk("IF_stall", if_stall, exp_stall);
        chk("inst_wr", inst_wr, 0);
        chk("inst_size", inst_size, 2);
        chk("inst_wdata", inst_wdata, 0);
        if (exp_req) chk("inst_addr", inst_addr, pc_reg);
        if (exp_valid) begin
            chk("IF_out_PC", if_out_pc, m_pc);
            chk("IF_out_inst", if_out_inst, m_inst);
        end
`ifdef INST_FETCH_ADEF_EN
        chk("IF_out_adef", if_out_adef, m_adef);
`endif
        obs_valid = if_out_valid;
        obs_stall = if_stall;
        if (inst_req) begin req_cycles++; last_req_addr = inst_addr; end
        if (inst_addr_ok) accepts++;
        if (!if_stall) stall_low_cnt++;
        if (if_out_valid) begin
            valid_cycles++;
            last_valid_pc   = if_out_pc;
            last_valid_inst = if_out_inst;
            if (if_out_inst == 32'hdeadbeef) saw_deadbeef = 1;
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
        end
        @(posedge clk);
        cyc++;
        if (m_have && (f || allow)) begin m_have = 0; m_adef = 0; end
        if (m_txn && inst_data_ok) begin
            m_txn = 0;
            if (m_live && !f) begin m_have = 1; m_pc = m_txn_pc; m_inst = inst_rdata; end
        end else if (m_txn && f) begin
            m_live = 0;
        end
        if (exp_req && inst_addr_ok) begin m_txn = 1; m_live = !f; m_txn_pc = pc_reg; end
        if (free && !aligned && !f) begin m_have = 1; m_pc = pc_reg; m_inst = 0; m_adef = 1; end
        m_started = 1;
        if (s_busy && inst_data_ok) s_busy = 0;
        else if (s_busy) s_data_cnt++;
        if (inst_req && inst_addr_ok) begin
            s_busy = 1; s_data_cnt = 0; s_req_cnt = 0;
            s_data = force_en ? force_data : mem(inst_addr);
        end else if (inst_req) begin
            s_req_cnt++;
        end
        if (!exp_stall) pc_reg = f ? tgt : pc_reg + 32'd4;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; flush = 0; out_allowin = 0;
        inst_addr_ok = 0; inst_data_ok = 0; inst_rdata = 0;
        if_in_pc = 32'hbfc00000;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        reset_checks();
        @(posedge clk); #1; rst = 0;

        // A: first fetch, addr_ok same cycle, data_ok next cycle
        stall_low_cnt = 0;
        for (int i = 0; i < 4; i++) step(0, 0, 1);
        chk("A_first_valid_cycle", first_valid_cyc, 3);
        chk("A_pc", last_valid_pc, 32'hbfc00000);
        chk("A_inst", last_valid_inst, 32'h3c1d0001);
        chk("A_stall_low_cycles", stall_low_cnt, 1);

        // B: ID back-pressure for 4 cycles in DONE
        valid_cycles = 0;
        for (int i = 0; i < 6; i++) step(0, 0, 0);
        chk("B_valid_held", valid_cycles, 4);
        chk("B_pc", last_valid_pc, 32'hbfc00004);
        step(0, 0, 1);
        step(0, 0, 1);
        chk("B_next_req", last_req_addr, 32'hbfc00008);
        step(0, 0, 1);
        step(0, 0, 1);

        // C: addr_ok delayed 3 cycles
        addr_delay = 3; req_cycles = 0; accepts = 0;
        for (int i = 0; i < 6; i++) step(0, 0, 1);
        chk("C_req_cycles", req_cycles, 4);
        chk("C_accepts", accepts, 1);
        chk("C_addr", last_req_addr, 32'hbfc0000c);
        addr_delay = 0;

        // D: flush in WAIT, stale data_ok two cycles later
        data_delay = 2; force_en = 1; force_data = 32'hdeadbeef; saw_deadbeef = 0;
        step(0, 0, 1);
        step(1, 32'hbfc00380, 1);
        step(0, 0, 1);
        step(0, 0, 1);
        data_delay = 0; force_en = 0;
        step(0, 0, 1);
        chk("D_redirect_req", last_req_addr, 32'hbfc00380);
        step(0, 0, 1);
        step(0, 0, 1);
        chk("D_no_deadbeef", saw_deadbeef, 0);

        // E: flush and out_allowin together in DONE
        step(0, 0, 0);
        step(0, 0, 0);
        valid_cycles = 0;
        step(1, 32'hbfc01000, 1);
        chk("E_valid", obs_valid, 0);
        chk("E_stall", obs_stall, 0);
        chk("E_valid_cycles", valid_cycles, 0);
        step(0, 0, 1);
        chk("E_redirect_req", last_req_addr, 32'hbfc01000);
        step(0, 0, 1);
        step(0, 0, 1);

        // F: reset mid-transaction
        data_delay = 3;
        step(0, 0, 1);
        step(0, 0, 1);
        @(negedge clk);
        rst = 1; flush = 0; inst_addr_ok = 0; inst_data_ok = 0;
        model_reset();
        data_delay = 0;
        #1;
        reset_checks();
        @(posedge clk); #1; rst = 0;
        for (int i = 0; i < 4; i++) step(0, 0, 1);

        // G: mixed traffic with random delays, flushes and back-pressure
        for (int i = 0; i < 400; i++) begin
            addr_delay = $urandom_range(0, 2);
            data_delay = $urandom_range(0, 2);
            step($urandom_range(0, 9) == 0,
                 32'hbfc10000 + ({22'd0, 8'($urandom_range(0, 255)), 2'b00}),
                 $urandom_range(0, 3) != 0);
        end
        addr_delay = 0; data_delay = 0;

`ifdef INST_FETCH_ADEF_EN
        // H: misaligned PC reported without touching the bus
        step(1, 32'hbfc00002, 0);
        req_cycles = 0;
        for (int i = 0; i < 8 && !m_have; i++) step(0, 0, 0);
        step(0, 0, 0);
        chk("H_adef", if_out_adef, 1);
        chk("H_pc", if_out_pc, 32'hbfc00002);
        chk("H_inst", if_out_inst, 0);
        chk("H_no_req", req_cycles, 0);
        step(1, 32'hbfc00100, 0);
        step(0, 0, 1);
        chk("H_adef_clear", if_out_adef, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
